depuncture: RTL
===============

Name: depuncture

Overview:
- Receive-side inverse of the puncturing stage. It sits directly downstream of the demodulator/LLR stage and upstream of the Viterbi decoder.
- Re-inserts an erasure word at every position that the transmit-side puncture vector dropped. This restores the original code-rate word sequence.
- Uses the same mask convention as the puncturing stage, so identical vector/length settings interoperate.
- Throughput is one output word per cycle, with a registered AXI-Stream output.

Parameters:
WIDTH, 32, data word width
MAX_LEN, 8, maximum puncture vector length
DEFAULT_VECTOR_LEN, 8, vector length reset value (1..MAX_LEN)
DEFAULT_PUNCTURE_VECTOR, 8'hFF, mask reset value; bit=1 means word kept, bit=0 means word punctured
ERASURE_VALUE, 0, WIDTH-bit word emitted at punctured positions

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high; clock clk
clear  in  1  synchronous soft reset, same effect as reset
vector_len_tdata  in  $clog2(MAX_LEN+1)  new vector length
vector_len_tvalid  in  1  length write strobe
vector_len_tready  out  1  constant 1
puncture_vector_tdata  in  MAX_LEN  new mask
puncture_vector_tvalid  in  1  mask write strobe
puncture_vector_tready  out  1  constant 1
i_tdata  in  WIDTH  punctured input word
i_tlast  in  1  end of packet
i_tvalid  in  1  input valid
i_tready  out  1  input ready
o_tdata  out  WIDTH  depunctured word
o_tlast  out  1  end of packet
o_tvalid  out  1  output valid
o_tready  in  1  output ready

Behaviour:
- Reset/clear:
  - vector_len=DEFAULT_VECTOR_LEN, vector=DEFAULT_PUNCTURE_VECTOR, idx=DEFAULT_VECTOR_LEN-1.
  - o_tvalid=0, o_tdata=0, o_tlast=0.
  - An in-flight output word is discarded.
- Index walk:
  - Current mask bit is vector[idx]. idx counts down from len-1 to 0, then wraps to len-1.
  - Within a period, bit len-1 is applied first.
- Length write:
  - Values 0 and values >MAX_LEN are clamped to MAX_LEN.
- Degenerate mask:
  - If vector[len-1:0]==0, the block treats the mask as all ones (pass-through). This prevents unbounded erasure generation.
- Output register:
  - load = !o_tvalid | o_tready.
  - Latency is 1 cycle from input accept to o_tvalid.
  - o_tdata, o_tlast and o_tvalid are stable while o_tvalid & !o_tready.
- Per cycle with load=1 and no config strobe:
  - Mask bit 1: i_tready=1. If i_tvalid, register {i_tlast,i_tdata}, set o_tvalid=1, and advance idx. Otherwise o_tvalid=0 and idx holds.
  - Mask bit 0: i_tready=0. Register ERASURE_VALUE with tlast=0, set o_tvalid=1, and advance idx.
  - An erasure is emitted only once at least one word of the current packet has been accepted (pkt_active=1). Punctured positions at packet start are emitted immediately on the first valid input, before that word.
- Packet boundary:
  - Accepting a word with i_tlast=1 reloads idx=len-1 and clears pkt_active.
  - Trailing punctured positions after the last real word are not emitted.
  - o_tlast is asserted only on the real word that carried i_tlast.
- Config strobe (either tvalid):
  - The new value is written this cycle. idx reloads to (new len if written, else old len)-1. pkt_active is cleared.
  - In this cycle i_tready=0 and no word is loaded. The output register holds its contents; o_tvalid clears only if o_tready=1.
- Simultaneous length and mask strobes: both are written, and idx uses the new length.
- Backpressure: while load=0, i_tready=0 and idx holds.

Decomposition:
- Shared package: mask-bit polarity constants (KEEP=1, PUNCTURED=0), LEN_W function $clog2(MAX_LEN+1), and the length clamp function. The same package is used by puncture.
- One natural sub-module: the existing axi_fifo_flop as the output register, with the mux {tlast,tdata}/erasure placed in front.

Test Plan:
- Default config, input 1,2,3,4 with tlast on 4 -> output 1,2,3,4 with tlast on 4 only; 1-cycle latency; one word per cycle.
- len=4, vector=4'b1101, input A..F with tlast on F -> output A,B,0,C,D,E,0,F; o_tlast only on F; i_tready low during each erasure cycle.
- Same config plus random o_tready (about 50%) -> sequence identical to the previous case; o_tdata stable while stalled; no word lost or duplicated.
- len=3, vector=3'b011 (first position punctured), input X,Y with tlast on Y -> output 0,X,Y; after tlast, the next packet begins with an erasure again.
- Mask write 4'b1010 mid-packet after 2 words -> i_tready=0 in the strobe cycle; following words follow the new pattern from bit 3.
- vector=0 with len=4 -> pass-through. Then reset asserted mid-stream with o_tvalid=1 -> o_tvalid=0 next cycle and idx restored to default.

Source files
------------

// File: rtl/depuncture_pkg.sv
// Shared definitions for the puncture / depuncture pair: mask polarity,
// length-field width and the length clamp applied on configuration writes.
package depuncture_pkg;

    localparam logic KEEP      = 1'b1;
    localparam logic PUNCTURED = 1'b0;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Zero and out-of-range lengths fall back to the full vector length.
    function automatic int clamp_len(input int len, input int max_len);
        if (len <= 0 || len > max_len) begin
            return max_len;
        end
        return len;
    endfunction

endpackage

// File: rtl/depuncture_if.sv
// AXI-Stream style word channel. A transfer happens on a rising clk edge
// where tvalid and tready are both high; a master holding tvalid keeps tdata/tlast stable.
interface depuncture_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tlast;
    logic             tvalid;
    logic             tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/depuncture_out_reg.sv
// Single-entry flop stage (axi_fifo_flop style): accepts a new word whenever
// it is empty or its current word is being taken downstream.
module depuncture_out_reg #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);

    assign in_ready = !out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/depuncture.sv
// Depuncture: walks the puncture mask from bit len-1 down to 0 and inserts
// an erasure word for every punctured position, one output word per cycle.
module depuncture
    import depuncture_pkg::*;
#(
    parameter int                     WIDTH                   = 32,
    parameter int                     MAX_LEN                 = 8,
    parameter int                     DEFAULT_VECTOR_LEN      = 8,
    parameter logic [MAX_LEN-1:0]     DEFAULT_PUNCTURE_VECTOR = 8'hFF,
    parameter logic [WIDTH-1:0]       ERASURE_VALUE           = '0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        clear,
    input  logic [len_w(MAX_LEN)-1:0]   vector_len_tdata,
    input  logic                        vector_len_tvalid,
    output logic                        vector_len_tready,
    input  logic [MAX_LEN-1:0]          puncture_vector_tdata,
    input  logic                        puncture_vector_tvalid,
    output logic                        puncture_vector_tready,
    depuncture_if.slave                 i,
    depuncture_if.master                o
);

    localparam int LEN_W = len_w(MAX_LEN);

    logic               rst;
    logic [LEN_W-1:0]   len_r, idx_r, new_len, idx_nxt;
    logic [MAX_LEN-1:0] vec_r, len_mask, eff_vec;
    logic               pkt_active, pkt_nxt;
    logic               cur_bit, cfg, load, accept, wr_valid;
    logic [WIDTH:0]     wr_data, out_data;

    assign rst                    = reset | clear;
    assign vector_len_tready      = 1'b1;
    assign puncture_vector_tready = 1'b1;

    always_comb begin
        new_len = vector_len_tvalid
                ? LEN_W'(clamp_len(int'(vector_len_tdata), MAX_LEN)) : len_r;

        for (int b = 0; b < MAX_LEN; b++) begin
            len_mask[b] = (b < int'(len_r));
        end
        // An all-punctured window would emit erasures forever; run it as pass-through.
        eff_vec = ((vec_r & len_mask) == '0) ? '1 : vec_r;

        cur_bit = KEEP;
        for (int b = 0; b < MAX_LEN; b++) begin
            if (idx_r == LEN_W'(b)) begin
                cur_bit = eff_vec[b];
            end
        end

        cfg      = vector_len_tvalid | puncture_vector_tvalid;
        i.tready = load & !cfg & (cur_bit == KEEP);
        accept   = i.tvalid & i.tready;
        // Erasures wait for the first real word of a packet so that leading
        // punctured slots come out ahead of it rather than between packets.
        wr_valid = load & !cfg &
                   ((cur_bit == PUNCTURED) ? (pkt_active | i.tvalid) : i.tvalid);
        wr_data  = (cur_bit == KEEP) ? {i.tlast, i.tdata} : {1'b0, ERASURE_VALUE};

        idx_nxt = idx_r;
        pkt_nxt = pkt_active;
        if (cfg) begin
            idx_nxt = new_len - LEN_W'(1);
            pkt_nxt = 1'b0;
        end else if (accept && i.tlast) begin
            idx_nxt = len_r - LEN_W'(1);
            pkt_nxt = 1'b0;
        end else if (wr_valid) begin
            idx_nxt = (idx_r == '0) ? len_r - LEN_W'(1) : idx_r - LEN_W'(1);
            if (accept) begin
                pkt_nxt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_r      <= LEN_W'(DEFAULT_VECTOR_LEN);
            vec_r      <= DEFAULT_PUNCTURE_VECTOR;
            idx_r      <= LEN_W'(DEFAULT_VECTOR_LEN - 1);
            pkt_active <= 1'b0;
        end else begin
            if (vector_len_tvalid) begin
                len_r <= new_len;
            end
            if (puncture_vector_tvalid) begin
                vec_r <= puncture_vector_tdata;
            end
            idx_r      <= idx_nxt;
            pkt_active <= pkt_nxt;
        end
    end

    depuncture_out_reg #(.W(WIDTH + 1)) u_out_reg (
        .clk       (clk),
        .reset     (rst),
        .in_data   (wr_data),
        .in_valid  (wr_valid),
        .in_ready  (load),
        .out_data  (out_data),
        .out_valid (o.tvalid),
        .out_ready (o.tready)
    );

    assign o.tlast = out_data[WIDTH];
    assign o.tdata = out_data[WIDTH-1:0];

endmodule
